transmitter: RTL
================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 Parameter CLKS_PER_BIT, default CLK_FREQ/BAUD (434), clock cycles per serial bit.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 txEn  input  1  transmit enable; new frames accepted only while high.
REQ-007 txStart  input  1  request to send in_data; level-sampled in IDLE.
REQ-008 in_data  input  8  parallel byte to serialize.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 txBusy  output  1  high while a frame is in progress.
REQ-011 txDone  output  1  one-cycle pulse at end of stop bit.

Function
REQ-012 FSM states IDLE, START, DATA, PARITY (macro only), STOP; one-hot or binary encoding is implementation choice.
REQ-013 IDLE: frame is accepted on an edge where txEn=1 and txStart=1; in_data is latched into a shift register on that edge; next state START.
REQ-014 tx is driven low on the cycle after acceptance (1-cycle latency); txBusy rises on the same cycle.
REQ-015 Each bit is held for exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads at every bit boundary.
REQ-016 DATA sends 8 bits LSB first; 3-bit index counts 0..7 and then moves to PARITY/STOP.
REQ-017 STOP drives tx high for one bit period; on its last cycle txDone pulses high for one cycle, txBusy falls, and the next state is IDLE.
REQ-018 Frame length is 10 bit periods (4340 cycles at defaults), or 11 with parity.
REQ-019 txStart while busy is ignored, with no queuing; in_data changes while busy do not affect the frame in flight.
REQ-020 txEn deasserted mid-frame: the current frame completes normally; no new frame is accepted.
REQ-021 txStart held high continuously with txEn=1: a new frame is accepted on the first IDLE cycle after txDone, giving back-to-back frames with exactly one idle cycle between stop and next start.
REQ-022 tx is registered (glitch-free) and is never X after reset.

Reset
REQ-023 While rst=1 on a clock edge: state=IDLE, tx=1, txBusy=0, txDone=0, counters=0, shift register=0.
REQ-024 Reset mid-frame aborts the frame; tx returns high on the next edge and no txDone is produced.

Configuration
REQ-025 Macro TX_PARITY_EN defined: PARITY state is inserted after DATA and sends the even-parity bit (XOR of the latched 8 bits) for one bit period.
REQ-026 Macro TX_PARITY_EN undefined: the PARITY state and its logic are absent; DATA goes directly to STOP.

Structure
REQ-027 Shared package uart_pkg holds the FSM state typedef, the default CLK_FREQ/BAUD constants and the CLKS_PER_BIT derivation, for reuse by receiver and transmitter.
REQ-028 One sub-module baud_tick (bit-period counter with reload/tick output) is natural and shall be reusable by the receiver; otherwise the design is flat.

Verification
REQ-029 Reset, then txEn=1 and a txStart pulse with in_data=8'hB5 -> tx sequence 0,1,0,1,0,1,1,0,1,1, each 434 cycles; txDone pulses once, 4340 cycles after tx falls.
REQ-030 Same with TX_PARITY_EN, in_data=8'hB5 (five ones) -> parity bit 1 before stop; frame is 4774 cycles.
REQ-031 txStart held high with in_data=8'h00 then 8'hFF -> two back-to-back frames, one idle-high cycle between them, two txDone pulses.
REQ-032 txEn=0 with a txStart pulse -> tx stays 1 and txBusy stays 0; txEn dropped mid-frame -> the frame completes and no further frame is sent.
REQ-033 rst asserted during DATA bit 3 -> tx=1, txBusy=0 on the next edge, and no txDone.
REQ-034 Loopback: transmitter tx wired to receiver rx, byte 8'h5A -> receiver out_data=8'h5A and right=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates, bit-period derivation, FSM states.
// Optional parity support is selected with TX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return clk_freq / baud;
  endfunction

  localparam int unsigned DEF_CLKS_PER_BIT =
    clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts while enabled, ticks on the last cycle of a bit.
// Shared by the UART transmitter and receiver.
module baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic reload,
  output logic tick
);

  localparam int unsigned W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = en && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (reload || !en) begin
      cnt_d = '0;
    end else if (at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: 8N1 frames, LSB first, registered line output.
// Define TX_PARITY_EN to insert an even-parity bit after the data bits.
module transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned BAUD         = DEF_BAUD,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in_data,
  output logic       tx,
  output logic       txBusy,
  output logic       txDone
);

  uart_state_e state_q;
  uart_state_e state_d;
  logic [7:0]  shreg_q;
  logic [7:0]  shreg_d;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic        tx_q;
  logic        tx_d;
  logic        busy_q;
  logic        busy_d;
  logic        done_q;
  logic        done_d;
  logic        reload;
  logic        tick;
`ifdef TX_PARITY_EN
  logic        par_q;
  logic        par_d;
`endif

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (busy_q),
    .reload(reload),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    reload  = 1'b0;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (txEn && txStart) begin
          state_d = ST_START;
          shreg_d = in_data;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          reload  = 1'b1;
`ifdef TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx     = tx_q;
  assign txBusy = busy_q;
  assign txDone = done_q;

endmodule
